// File: rtl/gpio_ctrl.sv
// gpio_ctrl: register-mapped GPIO block with synchronised, debounced inputs,
// per-bit edge detection, and a maskable level interrupt.
//
// Ports:
//   clk        - single clock, all state updates on its rising edge
//   reset      - asynchronous, active-high reset
//   addr       - 8-bit register address
//   write_data - 8-bit write data
//   write_en   - write strobe, sampled on the clk edge
//   read_en    - read enable
//   read_data  - combinational read data (0 when not reading a readable reg)
//   in_pins    - N_IN asynchronous external inputs
//   out_pins   - N_OUT driven outputs, straight from the OUT register
//   irq        - registered OR of (EDGE_STAT & IRQ_MASK)
//
// Register map:
//   0x00 OUT (RW)   0x01 OUT_SET (W1S)   0x02 OUT_CLR (W1C)
//   0x04 IN (RO)    0x05 EDGE_STAT (R/W1C)
//   0x06 IRQ_MASK (RW)   0x07 EDGE_MODE (RW, 0 = rising, 1 = falling)
module gpio_ctrl #(
  parameter int unsigned N_OUT           = 4,
  parameter int unsigned N_IN            = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       addr,
  input  logic [7:0]       write_data,
  input  logic             write_en,
  input  logic             read_en,
  output logic [7:0]       read_data,
  input  logic [N_IN-1:0]  in_pins,
  output logic [N_OUT-1:0] out_pins,
  output logic             irq
);

  localparam logic [7:0] ADDR_OUT       = 8'h00;
  localparam logic [7:0] ADDR_OUT_SET   = 8'h01;
  localparam logic [7:0] ADDR_OUT_CLR   = 8'h02;
  localparam logic [7:0] ADDR_IN        = 8'h04;
  localparam logic [7:0] ADDR_EDGE_STAT = 8'h05;
  localparam logic [7:0] ADDR_IRQ_MASK  = 8'h06;
  localparam logic [7:0] ADDR_EDGE_MODE = 8'h07;

  // Counter value on which the next differing sample completes the debounce.
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [N_OUT-1:0] out_reg;
  logic [N_IN-1:0]  sync1;
  logic [N_IN-1:0]  sync2;
  logic [N_IN-1:0]  db;
  logic [7:0]       cnt [N_IN];
  logic [N_IN-1:0]  edge_stat;
  logic [N_IN-1:0]  irq_mask;
  logic [N_IN-1:0]  edge_mode;

  logic [N_IN-1:0]  db_update;
  logic [N_IN-1:0]  edge_set;
  logic [N_IN-1:0]  stat_clr;
  logic [7:0]       rd;

  // Upper write_data bits are intentionally ignored for narrow configurations.
  logic unused_ok;
  assign unused_ok = &{1'b0, write_data};

  // A bit updates on the edge where its counter would reach DEBOUNCE_CYCLES.
  // Since an update always flips db, the new value alone identifies the
  // direction: sync2 ^ edge_mode is 1 for rising/mode 0 and falling/mode 1.
  always_comb begin
    db_update = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      db_update[i] = (sync2[i] != db[i]) && (cnt[i] == CNT_LAST);
    end
    edge_set = db_update & (sync2 ^ edge_mode);
    stat_clr = (write_en && addr == ADDR_EDGE_STAT) ? write_data[N_IN-1:0] : '0;
  end

  // Input path: 2-flop synchroniser, then per-bit debounce counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      for (int unsigned i = 0; i < N_IN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= in_pins;
      sync2 <= sync1;
      for (int unsigned i = 0; i < N_IN; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (db_update[i]) begin
          db[i]  <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 8'd1;
        end
      end
    end
  end

  // Edge status (set wins over a same-cycle clear) and registered interrupt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_stat <= '0;
      irq       <= 1'b0;
    end else begin
      edge_stat <= (edge_stat & ~stat_clr) | edge_set;
      irq       <= |(edge_stat & irq_mask);
    end
  end

  // Writable control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_reg   <= '0;
      irq_mask  <= '0;
      edge_mode <= '0;
    end else if (write_en) begin
      case (addr)
        ADDR_OUT:       out_reg   <= write_data[N_OUT-1:0];
        ADDR_OUT_SET:   out_reg   <= out_reg | write_data[N_OUT-1:0];
        ADDR_OUT_CLR:   out_reg   <= out_reg & ~write_data[N_OUT-1:0];
        ADDR_IRQ_MASK:  irq_mask  <= write_data[N_IN-1:0];
        ADDR_EDGE_MODE: edge_mode <= write_data[N_IN-1:0];
        default: ;
      endcase
    end
  end

  assign out_pins = out_reg;

  // Read mux reflects register contents before any same-cycle write.
  always_comb begin
    rd = '0;
    if (read_en) begin
      case (addr)
        ADDR_OUT:       rd[N_OUT-1:0] = out_reg;
        ADDR_IN:        rd[N_IN-1:0]  = db;
        ADDR_EDGE_STAT: rd[N_IN-1:0]  = edge_stat;
        ADDR_IRQ_MASK:  rd[N_IN-1:0]  = irq_mask;
        ADDR_EDGE_MODE: rd[N_IN-1:0]  = edge_mode;
        default: ;
      endcase
    end
  end

  assign read_data = rd;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed bench for gpio_ctrl (N_IN = N_OUT = 4, DEBOUNCE_CYCLES = 4).
// Expected values are queued as stimulus is applied and popped when the
// corresponding DUT output is sampled.
module tb_gpio_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] addr;
  logic [7:0] write_data;
  logic       write_en;
  logic       read_en;
  logic [7:0] read_data;
  logic [3:0] in_pins;
  logic [3:0] out_pins;
  logic       irq;

  int unsigned tests  = 0;
  int unsigned failed = 0;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];

  gpio_ctrl #(
    .N_OUT(4),
    .N_IN(4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .addr(addr),
    .write_data(write_data),
    .write_en(write_en),
    .read_en(read_en),
    .read_data(read_data),
    .in_pins(in_pins),
    .out_pins(out_pins),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [7:0] e);
    sb.push_back('{tag, e});
  endtask

  task automatic pop_check(input logic [7:0] obs);
    exp_t x;
    tests++;
    if (sb.size() == 0) begin
      failed++;
      $error("FAIL scoreboard_empty: observed %0h expected <queued value>", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.exp) else begin
        failed++;
        $error("FAIL %s: observed %0h expected %0h", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr       = a;
    write_data = d;
    write_en   = 1'b1;
    @(posedge clk);
    #1;
    write_en   = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    addr    = a;
    read_en = 1'b1;
    #1;
    d       = read_data;
    read_en = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [7:0] a, input logic [7:0] e);
    logic [7:0] v;
    push(tag, e);
    rd(a, v);
    pop_check(v);
  endtask

  task automatic chk_sig(input string tag, input logic [7:0] obs, input logic [7:0] e);
    push(tag, e);
    pop_check(obs);
  endtask

  initial begin
    logic [7:0] v;
    reset      = 1'b1;
    addr       = '0;
    write_data = '0;
    write_en   = 1'b0;
    read_en    = 1'b0;
    in_pins    = '0;

    // Reset state
    #2;
    chk_sig("rst_out_pins", {4'h0, out_pins}, 8'h00);
    chk_sig("rst_irq", {7'h0, irq}, 8'h00);
    tick();
    tick();
    chk_reg("rst_out_reg", 8'h00, 8'h00);
    chk_reg("rst_in", 8'h04, 8'h00);
    chk_reg("rst_stat", 8'h05, 8'h00);
    reset = 1'b0;
    tick();

    // OUT / OUT_SET / OUT_CLR
    push("out_write", 8'h0A);
    wr(8'h00, 8'h0A);
    pop_check({4'h0, out_pins});
    push("out_set", 8'h0B);
    wr(8'h01, 8'h01);
    pop_check({4'h0, out_pins});
    push("out_clr", 8'h03);
    wr(8'h02, 8'h08);
    pop_check({4'h0, out_pins});
    chk_reg("rd_out", 8'h00, 8'h03);
    chk_reg("rd_wo_set", 8'h01, 8'h00);
    chk_reg("rd_wo_clr", 8'h02, 8'h00);
    chk_reg("rd_unmapped_03", 8'h03, 8'h00);
    chk_reg("rd_unmapped_ff", 8'hFF, 8'h00);
    push("out_upper_ignored", 8'h0F);
    wr(8'h00, 8'hFF);
    pop_check({4'h0, out_pins});
    chk_reg("rd_out_upper", 8'h00, 8'h0F);
    addr    = 8'h00;
    read_en = 1'b0;
    #1;
    chk_sig("rd_en_low", read_data, 8'h00);

    // Same-cycle read and write shows the pre-write value
    addr       = 8'h00;
    write_data = 8'h05;
    write_en   = 1'b1;
    read_en    = 1'b1;
    #1;
    chk_sig("rw_prewrite", read_data, 8'h0F);
    push("rw_postwrite", 8'h05);
    @(posedge clk);
    #1;
    write_en = 1'b0;
    read_en  = 1'b0;
    pop_check({4'h0, out_pins});

    // Writes to read-only IN ignored
    wr(8'h04, 8'hFF);
    chk_reg("ro_in_ignored", 8'h04, 8'h00);

    // Rising edge on bit 0: IN and EDGE_STAT update exactly 6 edges later
    in_pins[0] = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      push("deb_in", (i == 6) ? 8'h01 : 8'h00);
      push("deb_stat", (i == 6) ? 8'h01 : 8'h00);
      tick();
      rd(8'h04, v);
      pop_check(v);
      rd(8'h05, v);
      pop_check(v);
    end

    // Clear status, mask bit 0, re-trigger, observe irq timing
    wr(8'h05, 8'h01);
    chk_reg("w1c_stat", 8'h05, 8'h00);
    wr(8'h06, 8'h01);
    chk_reg("rd_mask", 8'h06, 8'h01);
    in_pins[0] = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk_reg("fall_in", 8'h04, 8'h00);
    chk_reg("fall_no_stat_rise_mode", 8'h05, 8'h00);
    in_pins[0] = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk_reg("irq_stat_set", 8'h05, 8'h01);
    chk_sig("irq_not_yet", {7'h0, irq}, 8'h00);
    tick();
    chk_sig("irq_asserted", {7'h0, irq}, 8'h01);
    wr(8'h05, 8'h01);
    chk_reg("irq_stat_cleared", 8'h05, 8'h00);
    chk_sig("irq_still_high", {7'h0, irq}, 8'h01);
    tick();
    chk_sig("irq_deasserted", {7'h0, irq}, 8'h00);

    // Set wins over a clear landing on the same edge
    in_pins[0] = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    in_pins[0] = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    wr(8'h05, 8'h01);
    chk_reg("set_wins", 8'h05, 8'h01);
    wr(8'h05, 8'h01);
    chk_reg("clear_after_set", 8'h05, 8'h00);

    // 3-cycle glitch on bit 1 is rejected
    in_pins[1] = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    in_pins[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_reg("glitch_in", 8'h04, 8'h01);
    end
    chk_reg("glitch_stat", 8'h05, 8'h00);

    // Falling-edge mode on bit 2; mode changes alone never set status
    wr(8'h07, 8'h04);
    chk_reg("rd_mode", 8'h07, 8'h04);
    chk_reg("mode_chg_no_stat", 8'h05, 8'h00);
    wr(8'h07, 8'h05);
    chk_reg("mode_chg_no_stat2", 8'h05, 8'h00);
    wr(8'h07, 8'h04);
    in_pins[2] = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk_reg("fmode_in_high", 8'h04, 8'h05);
    chk_reg("fmode_no_rise_stat", 8'h05, 8'h00);
    in_pins[2] = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk_reg("fmode_in_low", 8'h04, 8'h01);
    chk_reg("fmode_fall_stat", 8'h05, 8'h04);

    // Raise irq via bit 2, then reset mid-debounce of bit 3
    wr(8'h06, 8'h04);
    tick();
    chk_sig("irq_bit2", {7'h0, irq}, 8'h01);
    wr(8'h00, 8'h0F);
    chk_sig("out_before_rst", {4'h0, out_pins}, 8'h0F);
    in_pins[3] = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    #2;
    reset = 1'b1;
    #1;
    chk_sig("async_rst_out", {4'h0, out_pins}, 8'h00);
    chk_sig("async_rst_irq", {7'h0, irq}, 8'h00);
    chk_reg("async_rst_stat", 8'h05, 8'h00);
    in_pins[3] = 1'b0;
    tick();
    chk_reg("rst_mask", 8'h06, 8'h00);
    chk_reg("rst_mode", 8'h07, 8'h00);
    chk_reg("rst_in_mid", 8'h04, 8'h00);
    tick();
    reset = 1'b0;

    // Bit 0 still held high: debounces after release and records a rise
    for (int i = 1; i <= 6; i++) begin
      push("post_rst_in", (i == 6) ? 8'h01 : 8'h00);
      tick();
      rd(8'h04, v);
      pop_check(v);
    end
    chk_reg("post_rst_stat", 8'h05, 8'h01);
    for (int i = 0; i < 10; i++) tick();
    chk_reg("no_stale_in", 8'h04, 8'h01);
    chk_reg("no_stale_stat", 8'h05, 8'h01);
    chk_sig("post_rst_irq", {7'h0, irq}, 8'h00);
    chk_sig("post_rst_out", {4'h0, out_pins}, 8'h00);

    tests++;
    assert (sb.size() == 0) else begin
      failed++;
      $error("FAIL scoreboard_drain: observed %0d expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
